fwd_pipe: RTL and testbench
===========================

# fwd_pipe

Parametrised result pipeline with built-in forwarding lookup for the in-order integer core. It tracks every in-flight register-writing instruction from EX through WB (DEPTH stages), carrying its destination, write enable, result data and a data-ready flag. It answers NSRC concurrent operand-forwarding queries with youngest-match priority and flags load-use style hazards. It replaces the fixed two-source forwarding muxes and the hand-wired EX/MEM and MEM/WB result registers.

## Interface
- DATA_W, 32, result data width
- ADDR_W, 5, register address width
- DEPTH, 3, number of tracked stages (stage 0 = youngest, DEPTH-1 = WB); legal 2..8
- NSRC, 2, number of forwarding query ports; legal 1..4
- FILL_STG, 1, stage at which late (load) results are filled; legal 0..DEPTH-1
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  freeze all stages this cycle
- flush_mask  in  DEPTH  bit k clears valid of stage k at the next edge
- in_valid  in  1  new entry enters stage 0
- in_we  in  1  entry writes the register file
- in_rd  in  ADDR_W  destination register
- in_rdy  in  1  in_data already valid (ALU result); 0 = late result (load)
- in_data  in  DATA_W  result data
- fill_valid  in  1  late result available for the entry in stage FILL_STG
- fill_data  in  DATA_W  late result
- src_addr  in  NSRC*ADDR_W  query addresses, port i at [i*ADDR_W +: ADDR_W]
- fwd_hit  out  NSRC  port i matched a ready in-flight entry
- fwd_data  out  NSRC*DATA_W  forwarded data, port i at [i*DATA_W +: DATA_W]
- hazard  out  1  some port matched a not-ready entry
- wb_valid, wb_we  out  1 each  stage DEPTH-1 entry flags
- wb_rd  out  ADDR_W  stage DEPTH-1 destination
- wb_data  out  DATA_W  stage DEPTH-1 data
- stall_cnt  out  32  hazard cycle count (see Configuration)

## Operation
- Each stage holds {valid, we, rd, rdy, data}.
- Reset: all valid, we and rdy are 0, and rd and data are 0. Every output is therefore 0 out of reset.
- Advance when stall=0:
  - stage k+1 takes stage k;
  - stage 0 takes the in_* inputs, with valid=in_valid;
  - the old stage DEPTH-1 content retires and is dropped.
- Hold when stall=1: all stages keep their contents, and the in_* inputs are ignored.
- Flush: the stage-k slot written at the edge gets valid=0 when flush_mask[k]=1. Flush overrides both advance and hold. On advance, bit k applies to the entry landing in stage k.
- Fill:
  - Applies when fill_valid=1 and the stage FILL_STG entry has valid=1 and rdy=0.
  - That entry's data becomes fill_data and rdy becomes 1. The filled value travels with the entry whether it advances or holds.
  - A fill to an empty or already-ready entry is ignored.
  - Fill and flush on the same entry: flush wins.
- Lookup, combinational, per port i:
  - A stage matches when valid & we & (rd == src_addr[i]) & (rd != 0).
  - Scan runs from stage 0 to DEPTH-1; the first match wins.
  - If the winner has rdy=1: fwd_hit[i]=1 and fwd_data[i] = that stage's data.
  - If the winner has rdy=0: fwd_hit[i]=0 and the port contributes to hazard. Older matches are never used.
  - With no match, fwd_hit[i]=0 and fwd_data[i]=0.
- hazard is the OR over ports of "winner not ready". The block never self-stalls; the hazard unit drives stall.
- An entry with in_rdy=0 that is never filled retires with wb_data equal to its stale data. Preventing this is the controller's responsibility.

## Timing
- in_* to stage 0 takes 1 cycle.
- An entry reaches wb_* DEPTH cycles after capture, plus 1 per stall cycle.
- Lookup outputs (fwd_*, hazard) are combinational from the stage registers and src_addr, with zero latency.
- wb_* are direct register outputs.
- Reset asserted mid-operation clears all stages immediately, without waiting for clk. The first capture occurs at the first edge after deassertion.

## Configuration
- FWD_STATS_EN defined: stall_cnt increments by 1 on every clk edge where hazard=1.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst.
- FWD_STATS_EN undefined: stall_cnt is tied to 0 and the counter logic is absent.

## Test plan
- Reset and basic flow: assert rst, then push in_rd=5, we=1, rdy=1, data=0x11 with stall=0. Required: wb_valid=1, wb_rd=5, wb_data=0x11 exactly 3 cycles later. All outputs are 0 during reset.
- Youngest-match priority: push rd=7 data=0xA, then rd=7 data=0xB, then query src_addr=7. Required: fwd_hit=1 and fwd_data=0xB. After a further stall=1 cycle the result is still 0xB.
- Load-use:
  - Push rd=3 with rdy=0, then query 3. Required: hazard=1 and fwd_hit=0.
  - Once the entry is in stage 1, apply fill_valid=1 with fill_data=0x55. Required next cycle: hazard=0, fwd_hit=1, fwd_data=0x55.
- Zero and we filtering:
  - Entries with rd=0 (we=1) and with rd=4 (we=0) are present. Query 0 and 4. Required: fwd_hit=0 and hazard=0 on both ports.
- Flush versus fill:
  - Apply flush_mask=3'b010 and fill_valid on the same cycle, both targeting the not-ready entry in stage 1. Required: the entry is gone (valid=0), no hit on a later query, and it never appears on wb_valid.
- Stats (FWD_STATS_EN): hold hazard=1 with stall=1 for 10 cycles. Required: stall_cnt=10, and stall_cnt returns to 0 on async rst.

Source files
------------

// File: rtl/fwd_pipe.sv
// fwd_pipe: in-order result pipeline tracking register-writing instructions
// from EX (stage 0) to WB (stage DEPTH-1), with NSRC concurrent operand
// forwarding lookups (youngest match wins) and late-result fill for loads.
// Optional build macro FWD_STATS_EN adds a saturating hazard-cycle counter
// on stall_cnt; without it stall_cnt is tied to zero.
module fwd_pipe #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int NSRC     = 2,
  parameter int FILL_STG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic [DEPTH-1:0]       flush_mask,
  input  logic                   in_valid,
  input  logic                   in_we,
  input  logic [ADDR_W-1:0]      in_rd,
  input  logic                   in_rdy,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   fill_valid,
  input  logic [DATA_W-1:0]      fill_data,
  input  logic [NSRC*ADDR_W-1:0] src_addr,
  output logic [NSRC-1:0]        fwd_hit,
  output logic [NSRC*DATA_W-1:0] fwd_data,
  output logic                   hazard,
  output logic                   wb_valid,
  output logic                   wb_we,
  output logic [ADDR_W-1:0]      wb_rd,
  output logic [DATA_W-1:0]      wb_data,
  output logic [31:0]            stall_cnt
);

  logic              stValid [DEPTH];
  logic              stWe    [DEPTH];
  logic [ADDR_W-1:0] stRd    [DEPTH];
  logic              stRdy   [DEPTH];
  logic [DATA_W-1:0] stData  [DEPTH];

  logic              effRdy  [DEPTH];
  logic [DATA_W-1:0] effData [DEPTH];

  logic              nxValid [DEPTH];
  logic              nxWe    [DEPTH];
  logic [ADDR_W-1:0] nxRd    [DEPTH];
  logic              nxRdy   [DEPTH];
  logic [DATA_W-1:0] nxData  [DEPTH];

  logic              fillApply;
  logic [NSRC-1:0]   portDone;

  assign fillApply = fill_valid & stValid[FILL_STG] & ~stRdy[FILL_STG];

  // Build next stage contents: fill the waiting load first so the filled value
  // travels with its entry, then shift or hold, and finally apply flushes so a
  // flush always beats a fill on the same slot.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      effRdy[k]  = stRdy[k];
      effData[k] = stData[k];
    end
    if (fillApply) begin
      effRdy[FILL_STG]  = 1'b1;
      effData[FILL_STG] = fill_data;
    end

    for (int k = 0; k < DEPTH; k++) begin
      nxValid[k] = stValid[k];
      nxWe[k]    = stWe[k];
      nxRd[k]    = stRd[k];
      nxRdy[k]   = effRdy[k];
      nxData[k]  = effData[k];
    end

    if (!stall) begin
      nxValid[0] = in_valid;
      nxWe[0]    = in_we;
      nxRd[0]    = in_rd;
      nxRdy[0]   = in_rdy;
      nxData[0]  = in_data;
      for (int k = 1; k < DEPTH; k++) begin
        nxValid[k] = stValid[k-1];
        nxWe[k]    = stWe[k-1];
        nxRd[k]    = stRd[k-1];
        nxRdy[k]   = effRdy[k-1];
        nxData[k]  = effData[k-1];
      end
    end

    for (int k = 0; k < DEPTH; k++) begin
      if (flush_mask[k]) begin
        nxValid[k] = 1'b0;
      end
    end
  end

  // Stage registers; reset clears every field immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        stValid[k] <= 1'b0;
        stWe[k]    <= 1'b0;
        stRd[k]    <= '0;
        stRdy[k]   <= 1'b0;
        stData[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stValid[k] <= nxValid[k];
        stWe[k]    <= nxWe[k];
        stRd[k]    <= nxRd[k];
        stRdy[k]   <= nxRdy[k];
        stData[k]  <= nxData[k];
      end
    end
  end

  // Forwarding lookup: per port, the youngest valid writer of a nonzero
  // register decides the outcome; an unready winner raises hazard and older
  // entries are never consulted.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    hazard   = 1'b0;
    portDone = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!portDone[i] && stValid[k] && stWe[k] && (stRd[k] != '0) &&
            (stRd[k] == src_addr[i*ADDR_W +: ADDR_W])) begin
          portDone[i] = 1'b1;
          if (stRdy[k]) begin
            fwd_hit[i]                   = 1'b1;
            fwd_data[i*DATA_W +: DATA_W] = stData[k];
          end else begin
            hazard = 1'b1;
          end
        end
      end
    end
  end

  assign wb_valid = stValid[DEPTH-1];
  assign wb_we    = stWe[DEPTH-1];
  assign wb_rd    = stRd[DEPTH-1];
  assign wb_data  = stData[DEPTH-1];

`ifdef FWD_STATS_EN
  logic [31:0] statCnt;

  // Count clock edges that see a hazard, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      statCnt <= '0;
    end else if (hazard && (statCnt != 32'hFFFF_FFFF)) begin
      statCnt <= statCnt + 32'd1;
    end
  end

  assign stall_cnt = statCnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_pipe.sv
// tb_fwd_pipe: scoreboard bench for fwd_pipe. A reference model of the
// in-flight entries predicts lookup results every cycle and each WB
// presentation; a monitor compares them against the DUT on the falling edge.
module tb_fwd_pipe;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int DEPTH    = 3;
  localparam int NSRC     = 2;
  localparam int FILL_STG = 1;

  typedef struct {
    logic                   stall;
    logic [DEPTH-1:0]       flush;
    logic                   valid;
    logic                   we;
    logic [ADDR_W-1:0]      rd;
    logic                   rdy;
    logic [DATA_W-1:0]      data;
    logic                   fillV;
    logic [DATA_W-1:0]      fillD;
    logic [NSRC*ADDR_W-1:0] src;
  } stim_t;

  typedef struct {
    int                     cyc;
    logic [NSRC-1:0]        hit;
    logic [NSRC*DATA_W-1:0] data;
    logic                   haz;
    logic [31:0]            stat;
  } lkExp_t;

  typedef struct {
    int                cyc;
    logic              we;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wbExp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   stall;
  logic [DEPTH-1:0]       flush_mask;
  logic                   in_valid;
  logic                   in_we;
  logic [ADDR_W-1:0]      in_rd;
  logic                   in_rdy;
  logic [DATA_W-1:0]      in_data;
  logic                   fill_valid;
  logic [DATA_W-1:0]      fill_data;
  logic [NSRC*ADDR_W-1:0] src_addr;
  logic [NSRC-1:0]        fwd_hit;
  logic [NSRC*DATA_W-1:0] fwd_data;
  logic                   hazard;
  logic                   wb_valid;
  logic                   wb_we;
  logic [ADDR_W-1:0]      wb_rd;
  logic [DATA_W-1:0]      wb_data;
  logic [31:0]            stall_cnt;

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;
  logic monEn = 1'b0;

  lkExp_t lkQ[$];
  wbExp_t wbQ[$];
  lkExp_t monLk;
  wbExp_t monWb;
  stim_t  st;

  // Reference model: one record per pipeline slot, youngest first.
  logic              mValid [DEPTH];
  logic              mWe    [DEPTH];
  logic [ADDR_W-1:0] mRd    [DEPTH];
  logic              mRdy   [DEPTH];
  logic [DATA_W-1:0] mData  [DEPTH];
  logic [31:0]       mStat;

  fwd_pipe #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NSRC(NSRC), .FILL_STG(FILL_STG)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush_mask(flush_mask),
    .in_valid(in_valid), .in_we(in_we), .in_rd(in_rd), .in_rdy(in_rdy),
    .in_data(in_data), .fill_valid(fill_valid), .fill_data(fill_data),
    .src_addr(src_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .hazard(hazard), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .stall_cnt(stall_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cycleNo);
    end
  endtask

  task automatic modelClear();
    for (int k = 0; k < DEPTH; k++) begin
      mValid[k] = 1'b0;
      mWe[k]    = 1'b0;
      mRd[k]    = '0;
      mRdy[k]   = 1'b0;
      mData[k]  = '0;
    end
    mStat = '0;
  endtask

  function automatic lkExp_t modelLookup(input logic [NSRC*ADDR_W-1:0] src);
    lkExp_t r;
    logic [ADDR_W-1:0] a;
    r.cyc  = cycleNo;
    r.hit  = '0;
    r.data = '0;
    r.haz  = 1'b0;
    r.stat = mStat;
    for (int i = 0; i < NSRC; i++) begin
      a = src[i*ADDR_W +: ADDR_W];
      if (a != '0) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (mValid[k] && mWe[k] && (mRd[k] == a)) begin
            if (mRdy[k]) begin
              r.hit[i] = 1'b1;
              r.data[i*DATA_W +: DATA_W] = mData[k];
            end else begin
              r.haz = 1'b1;
            end
            break;
          end
        end
      end
    end
    return r;
  endfunction

  task automatic modelStep(input stim_t s);
    if (s.fillV && mValid[FILL_STG] && !mRdy[FILL_STG]) begin
      mRdy[FILL_STG]  = 1'b1;
      mData[FILL_STG] = s.fillD;
    end
    if (!s.stall) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        mValid[k] = mValid[k-1];
        mWe[k]    = mWe[k-1];
        mRd[k]    = mRd[k-1];
        mRdy[k]   = mRdy[k-1];
        mData[k]  = mData[k-1];
      end
      mValid[0] = s.valid;
      mWe[0]    = s.we;
      mRd[0]    = s.rd;
      mRdy[0]   = s.rdy;
      mData[0]  = s.data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (s.flush[k]) mValid[k] = 1'b0;
    end
  endtask

  task automatic driveInputs(input stim_t s);
    stall      = s.stall;
    flush_mask = s.flush;
    in_valid   = s.valid;
    in_we      = s.we;
    in_rd      = s.rd;
    in_rdy     = s.rdy;
    in_data    = s.data;
    fill_valid = s.fillV;
    fill_data  = s.fillD;
    src_addr   = s.src;
  endtask

  // One clock cycle: drive, predict this cycle's lookup, step across the edge,
  // then predict what WB shows in the new cycle.
  task automatic applyStimulus(input stim_t s);
    lkExp_t le;
    wbExp_t we;
    driveInputs(s);
    le = modelLookup(s.src);
    lkQ.push_back(le);
    @(posedge clk);
    #1;
    modelStep(s);
`ifdef FWD_STATS_EN
    if (le.haz && (mStat != 32'hFFFF_FFFF)) mStat = mStat + 32'd1;
`endif
    cycleNo++;
    if (mValid[DEPTH-1]) begin
      we.cyc  = cycleNo;
      we.we   = mWe[DEPTH-1];
      we.rd   = mRd[DEPTH-1];
      we.data = mData[DEPTH-1];
      wbQ.push_back(we);
    end
  endtask

  function automatic stim_t idleStim(input logic [ADDR_W-1:0] q0, input logic [ADDR_W-1:0] q1);
    stim_t s;
    s.stall = 1'b0;
    s.flush = '0;
    s.valid = 1'b0;
    s.we    = 1'b0;
    s.rd    = '0;
    s.rdy   = 1'b0;
    s.data  = '0;
    s.fillV = 1'b0;
    s.fillD = '0;
    s.src   = {q1, q0};
    return s;
  endfunction

  function automatic stim_t pushStim(input logic [ADDR_W-1:0] rd, input logic rdy,
                                     input logic [DATA_W-1:0] data, input logic [ADDR_W-1:0] q);
    stim_t s;
    s       = idleStim(q, q);
    s.valid = 1'b1;
    s.we    = 1'b1;
    s.rd    = rd;
    s.rdy   = rdy;
    s.data  = data;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.stall = ($urandom_range(0, 4) == 0);
    for (int k = 0; k < DEPTH; k++) s.flush[k] = ($urandom_range(0, 9) == 0);
    s.valid = ($urandom_range(0, 9) < 7);
    s.we    = ($urandom_range(0, 4) != 0);
    s.rd    = ADDR_W'($urandom_range(0, 7));
    s.rdy   = ($urandom_range(0, 9) < 6);
    s.data  = $urandom;
    s.fillV = ($urandom_range(0, 9) < 4);
    s.fillD = $urandom;
    for (int i = 0; i < NSRC; i++) s.src[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
    return s;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wb_valid"}, 64'(wb_valid), 64'(0));
    checkOutput({tag, "_wb_we"}, 64'(wb_we), 64'(0));
    checkOutput({tag, "_wb_rd"}, 64'(wb_rd), 64'(0));
    checkOutput({tag, "_wb_data"}, 64'(wb_data), 64'(0));
    checkOutput({tag, "_fwd_hit"}, 64'(fwd_hit), 64'(0));
    checkOutput({tag, "_fwd_data"}, 64'(fwd_data), 64'(0));
    checkOutput({tag, "_hazard"}, 64'(hazard), 64'(0));
    checkOutput({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(0));
  endtask

  // Asynchronous reset in the middle of a cycle, checked before the next edge.
  task automatic doReset();
    monEn = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkAllZero("async_rst");
    driveInputs(idleStim('0, '0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelClear();
    lkQ.delete();
    wbQ.delete();
    cycleNo++;
    monEn = 1'b1;
  endtask

  // Monitor: compare lookup outputs every cycle, and pop a WB expectation
  // whenever the DUT presents a valid retirement.
  always @(negedge clk) begin
    if (monEn) begin
      if (lkQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL lookup_queue actual=empty required=entry (cycle %0d)", cycleNo);
      end else begin
        monLk = lkQ.pop_front();
        checkOutput("fwd_hit", 64'(fwd_hit), 64'(monLk.hit));
        checkOutput("fwd_data", 64'(fwd_data), 64'(monLk.data));
        checkOutput("hazard", 64'(hazard), 64'(monLk.haz));
        checkOutput("stall_cnt", 64'(stall_cnt), 64'(monLk.stat));
      end
      while ((wbQ.size() > 0) && (wbQ[0].cyc < cycleNo)) begin
        monWb = wbQ.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL wb_missing actual=wb_valid 0 required=rd %0d data %0h at cycle %0d",
                 monWb.rd, monWb.data, monWb.cyc);
      end
      if (wb_valid) begin
        if ((wbQ.size() == 0) || (wbQ[0].cyc != cycleNo)) begin
          checks++;
          errors++;
          $display("[TB] FAIL wb_unexpected actual=wb_valid 1 rd %0d required=no retirement (cycle %0d)",
                   wb_rd, cycleNo);
        end else begin
          monWb = wbQ.pop_front();
          checkOutput("wb_we", 64'(wb_we), 64'(monWb.we));
          checkOutput("wb_rd", 64'(wb_rd), 64'(monWb.rd));
          checkOutput("wb_data", 64'(wb_data), 64'(monWb.data));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    st = pushStim(5'd9, 1'b1, 32'hFFFF_FFFF, 5'd9);
    st.fillV = 1'b1;
    driveInputs(st);
    modelClear();
    @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;
    monEn = 1'b1;

    // Basic flow: entry appears on WB three cycles after capture.
    applyStimulus(pushStim(5'd5, 1'b1, 32'h11, 5'd0));
    applyStimulus(idleStim('0, '0));
    applyStimulus(idleStim('0, '0));
    checkOutput("flow_wb_valid", 64'(wb_valid), 64'(1));
    checkOutput("flow_wb_rd", 64'(wb_rd), 64'(5));
    checkOutput("flow_wb_data", 64'(wb_data), 64'(32'h11));

    // Youngest match wins, and still wins across a stall.
    applyStimulus(pushStim(5'd7, 1'b1, 32'hA, 5'd7));
    applyStimulus(pushStim(5'd7, 1'b1, 32'hB, 5'd7));
    checkOutput("young_hit", 64'(fwd_hit[0]), 64'(1));
    checkOutput("young_data", 64'(fwd_data[DATA_W-1:0]), 64'(32'hB));
    st = pushStim(5'd7, 1'b1, 32'hC, 5'd7);
    st.stall = 1'b1;
    applyStimulus(st);
    checkOutput("young_stall_data", 64'(fwd_data[DATA_W-1:0]), 64'(32'hB));

    // Load-use hazard then fill in stage 1.
    applyStimulus(pushStim(5'd3, 1'b0, 32'h0, 5'd3));
    checkOutput("load_hazard", 64'(hazard), 64'(1));
    checkOutput("load_hit", 64'(fwd_hit), 64'(0));
    applyStimulus(idleStim(5'd3, 5'd3));
    checkOutput("load_hazard_s1", 64'(hazard), 64'(1));
    st = idleStim(5'd3, 5'd3);
    st.fillV = 1'b1;
    st.fillD = 32'h55;
    applyStimulus(st);
    checkOutput("fill_hazard", 64'(hazard), 64'(0));
    checkOutput("fill_hit", 64'(fwd_hit[0]), 64'(1));
    checkOutput("fill_data", 64'(fwd_data[DATA_W-1:0]), 64'(32'h55));

    // r0 and non-writing entries never forward.
    st = pushStim(5'd0, 1'b1, 32'h99, 5'd0);
    st.src = {5'd4, 5'd0};
    applyStimulus(st);
    st = pushStim(5'd4, 1'b1, 32'h44, 5'd0);
    st.we = 1'b0;
    st.src = {5'd4, 5'd0};
    applyStimulus(st);
    checkOutput("filter_hit", 64'(fwd_hit), 64'(0));
    checkOutput("filter_hazard", 64'(hazard), 64'(0));

    // Flush beats fill on the held stage-1 entry; it never retires.
    applyStimulus(pushStim(5'd9, 1'b0, 32'h0, 5'd9));
    applyStimulus(idleStim(5'd9, 5'd9));
    st = idleStim(5'd9, 5'd9);
    st.stall = 1'b1;
    st.flush = 3'b010;
    st.fillV = 1'b1;
    st.fillD = 32'h77;
    applyStimulus(st);
    checkOutput("flush_hit", 64'(fwd_hit), 64'(0));
    checkOutput("flush_hazard", 64'(hazard), 64'(0));
    applyStimulus(idleStim(5'd9, 5'd9));
    checkOutput("flush_wb_valid", 64'(wb_valid), 64'(0));

    // Randomized traffic.
    for (int n = 0; n < 400; n++) applyStimulus(randStim());

    doReset();

    // Hazard held for ten stalled edges.
    applyStimulus(pushStim(5'd6, 1'b0, 32'h0, 5'd6));
    for (int n = 0; n < 10; n++) begin
      st = idleStim(5'd6, 5'd6);
      st.stall = 1'b1;
      applyStimulus(st);
    end
`ifdef FWD_STATS_EN
    checkOutput("stats_ten", 64'(stall_cnt), 64'(10));
`else
    checkOutput("stats_tied", 64'(stall_cnt), 64'(0));
`endif
    doReset();

    for (int n = 0; n < 250; n++) applyStimulus(randStim());

    monEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
